// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: 8N1 UART transmitter that drains a byte FIFO.
// Pops and latches head data on one edge; bit timing restarts with each pop.
module fifo_uart_tx #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       empty,
  input  logic [7:0] r_Data,
  output logic       rd,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [2:0]    idx;
  logic [2:0]    idx_nx;
  logic [7:0]    shift;
  logic [7:0]    shift_nx;
  logic          tx_nx;
  logic          busy_nx;
  logic          bit_end;

  assign bit_end = (cnt == LAST);
  assign rd      = (state == IDLE) & ~empty & ~rst;
  assign tx_done = (state == STOP) & bit_end;

  // tx is loaded with the level of the bit about to start, so it is registered
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    shift_nx = shift;
    tx_nx    = 1'b1;
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (rd) begin
          state_nx = START;
          shift_nx = r_Data;
          idx_nx   = '0;
          tx_nx    = 1'b0;
        end
      end
      START: begin
        tx_nx = 1'b0;
        if (bit_end) begin
          state_nx = DATA;
          cnt_nx   = '0;
          tx_nx    = shift[0];
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DATA: begin
        tx_nx = shift[0];
        if (bit_end) begin
          cnt_nx   = '0;
          shift_nx = {1'b0, shift[7:1]};
          idx_nx   = idx + 1'b1;
          if (idx == 3'd7) begin
            state_nx = STOP;
            tx_nx    = 1'b1;
          end else begin
            tx_nx = shift[1];
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      idx     <= idx_nx;
      shift   <= shift_nx;
      tx      <= tx_nx;
      tx_busy <= busy_nx;
    end
  end

endmodule
